// File: rtl/gtx_pkg.sv
// Shared constants and types for the GTX receive path.
package gtx_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;

  localparam int unsigned LANE0 = 0;
  localparam int unsigned LANE1 = 1;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_t;

endpackage

// File: rtl/gtx_rx_align.sv
// K28.5 word aligner: moves the comma into the low byte lane and tracks link lock.
// Optional saturating code-error counter enabled by GTX_RX_ALIGN_ERR_CNT_EN.
module gtx_rx_align
  import gtx_pkg::*;
#(
  parameter logic [7:0]  COMMA    = K28_5,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [1:0]  ctrl_i,
  input  logic [15:0] data_i,
  input  logic [1:0]  disperr_i,
  input  logic [1:0]  notintable_i,
  output logic [1:0]  ctrl_o,
  output logic [15:0] data_o,
  output logic        valid_o,
  output logic        locked_o,
  output logic        swap_o,
  output logic [15:0] err_cnt_o
);

  localparam logic [3:0] LOCK_CNT_C = LOCK_CNT[3:0];
  localparam logic [3:0] LOSS_CNT_C = LOSS_CNT[3:0];

  align_state_t state_r;
  logic [3:0]   cnt_r;
  logic [3:0]   bad_r;
  logic         swap_r;
  logic         locked_r;
  logic         valid_r;
  logic [7:0]   prev_data_r;
  logic         prev_k_r;
  logic [15:0]  data_r;
  logic [1:0]   ctrl_r;

  logic         comma0_s;
  logic         comma1_s;
  logic         err_s;
  logic         sel_s;
  logic         opp_s;
  logic         good_s;
  logic         bad_ev_s;
  logic [15:0]  mux_data_s;
  logic [1:0]   mux_ctrl_s;

  assign comma0_s = ctrl_i[LANE0] && (data_i[7:0]  == COMMA);
  assign comma1_s = ctrl_i[LANE1] && (data_i[15:8] == COMMA);
  assign err_s    = |(disperr_i | notintable_i);
  assign sel_s    = swap_r ? comma1_s : comma0_s;
  assign opp_s    = swap_r ? comma0_s : comma1_s;
  // An errored word never counts as good, so good and bad are exclusive.
  assign good_s   = sel_s && !err_s;
  assign bad_ev_s = err_s || (opp_s && !sel_s);

  // Byte-lane mux: with swap the high byte of the previous word becomes the low lane.
  always_comb begin
    mux_data_s = data_i;
    mux_ctrl_s = ctrl_i;
    if (swap_r) begin
      mux_data_s = {data_i[7:0], prev_data_r};
      mux_ctrl_s = {ctrl_i[LANE0], prev_k_r};
    end else begin
      mux_data_s = data_i;
      mux_ctrl_s = ctrl_i;
    end
  end

  // Alignment state machine with registered lock, valid and swap status.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r  <= HUNT;
      cnt_r    <= 4'd0;
      bad_r    <= 4'd0;
      swap_r   <= 1'b0;
      locked_r <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      case (state_r)
        HUNT: begin
          if (!err_s && (comma0_s ^ comma1_s)) begin
            swap_r  <= comma1_s;
            cnt_r   <= 4'd1;
            state_r <= VERIFY;
          end
        end
        VERIFY: begin
          if (good_s) begin
            cnt_r <= cnt_r + 4'd1;
            if ((cnt_r + 4'd1) == LOCK_CNT_C) begin
              state_r  <= LOCKED;
              bad_r    <= 4'd0;
              locked_r <= 1'b1;
              valid_r  <= 1'b1;
            end
          end else if (bad_ev_s) begin
            state_r <= HUNT;
            cnt_r   <= 4'd0;
          end
        end
        LOCKED: begin
          if (good_s) begin
            bad_r <= 4'd0;
          end else if (bad_ev_s) begin
            if ((bad_r + 4'd1) == LOSS_CNT_C) begin
              state_r  <= HUNT;
              cnt_r    <= 4'd0;
              bad_r    <= 4'd0;
              locked_r <= 1'b0;
              valid_r  <= 1'b0;
            end else begin
              bad_r <= bad_r + 4'd1;
            end
          end
        end
        default: begin
          state_r  <= HUNT;
          cnt_r    <= 4'd0;
          bad_r    <= 4'd0;
          locked_r <= 1'b0;
          valid_r  <= 1'b0;
        end
      endcase
    end
  end

  // Previous-word capture and registered aligned output.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prev_data_r <= 8'h00;
      prev_k_r    <= 1'b0;
      data_r      <= 16'h0000;
      ctrl_r      <= 2'b00;
    end else begin
      prev_data_r <= data_i[15:8];
      prev_k_r    <= ctrl_i[LANE1];
      data_r      <= mux_data_s;
      ctrl_r      <= mux_ctrl_s;
    end
  end

`ifdef GTX_RX_ALIGN_ERR_CNT_EN
  logic [15:0] err_cnt_r;

  // Saturating count of errored words seen while locked; cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_cnt_r <= 16'h0000;
    end else if ((state_r == LOCKED) && err_s && (err_cnt_r != 16'hFFFF)) begin
      err_cnt_r <= err_cnt_r + 16'h0001;
    end
  end

  assign err_cnt_o = err_cnt_r;
`else
  assign err_cnt_o = 16'h0000;
`endif

  assign data_o   = data_r;
  assign ctrl_o   = ctrl_r;
  assign valid_o  = valid_r;
  assign locked_o = locked_r;
  assign swap_o   = swap_r;

endmodule

// File: tb/tb_gtx_rx_align.sv
// Bench for gtx_rx_align: directed lock/loss scenarios plus randomized traffic vs a behavioural model.
module tb_gtx_rx_align;

  localparam int LOCK = 4;
  localparam int LOSS = 8;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic [1:0]  ctrl_i, disperr_i, notintable_i, ctrl_o;
  logic [15:0] data_i, data_o, err_cnt_o;
  logic        valid_o, locked_o, swap_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  gtx_rx_align dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .ctrl_i(ctrl_i), .data_i(data_i),
    .disperr_i(disperr_i), .notintable_i(notintable_i), .ctrl_o(ctrl_o),
    .data_o(data_o), .valid_o(valid_o), .locked_o(locked_o), .swap_o(swap_o),
    .err_cnt_o(err_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Behavioural reference: hunting flag, streak of aligned commas, misses while locked.
  bit          m_hunting, m_locked, m_swap, m_prevk;
  int          m_streak, m_miss;
  logic [7:0]  m_prev;
  logic [15:0] e_data, e_err;
  logic [1:0]  e_ctrl;

  task automatic model_reset();
    m_hunting = 1; m_locked = 0; m_swap = 0; m_prevk = 0;
    m_streak = 0; m_miss = 0; m_prev = 8'h00;
    e_data = 16'h0000; e_ctrl = 2'b00; e_err = 16'h0000;
  endtask

  task automatic model_step(input logic [1:0] c, input logic [15:0] d, input logic [1:0] e);
    bit c0, c1, is_err, sel, opp;
    c0 = c[0] && (d[7:0] == 8'hBC);
    c1 = c[1] && (d[15:8] == 8'hBC);
    is_err = (e != 2'b00);
    e_data = m_swap ? {d[7:0], m_prev} : d;
    e_ctrl = m_swap ? {c[0], m_prevk} : c;
`ifdef GTX_RX_ALIGN_ERR_CNT_EN
    if (m_locked && is_err && e_err != 16'hFFFF) e_err = e_err + 16'd1;
`endif
    sel = m_swap ? c1 : c0;
    opp = m_swap ? c0 : c1;
    if (m_hunting) begin
      if (!is_err && (c0 != c1)) begin
        m_hunting = 0; m_swap = c1; m_streak = 1;
      end
    end else if (!m_locked) begin
      if (sel && !is_err) begin
        m_streak++;
        if (m_streak == LOCK) begin m_locked = 1; m_miss = 0; end
      end else if (is_err || opp) begin
        m_hunting = 1; m_streak = 0;
      end
    end else begin
      if (sel && !is_err) m_miss = 0;
      else if (is_err || opp) begin
        m_miss++;
        if (m_miss == LOSS) begin m_locked = 0; m_hunting = 1; m_streak = 0; m_miss = 0; end
      end
    end
    m_prev = d[15:8];
    m_prevk = c[1];
  endtask

  task automatic step(input logic [1:0] c, input logic [15:0] d,
                      input logic [1:0] de, input logic [1:0] nt);
    ctrl_i = c; data_i = d; disperr_i = de; notintable_i = nt;
    @(posedge clk);
    model_step(c, d, de | nt);
    #1;
    chk("data", {16'h0, data_o}, {16'h0, e_data});
    chk("ctrl", {30'h0, ctrl_o}, {30'h0, e_ctrl});
    chk("locked", {31'h0, locked_o}, {31'h0, m_locked});
    chk("valid", {31'h0, valid_o}, {31'h0, m_locked});
    chk("swap", {31'h0, swap_o}, {31'h0, m_swap});
    chk("errcnt", {16'h0, err_cnt_o}, {16'h0, e_err});
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    #1;
    chk("rst_data", {16'h0, data_o}, 32'h0);
    chk("rst_ctrl", {30'h0, ctrl_o}, 32'h0);
    chk("rst_locked", {31'h0, locked_o}, 32'h0);
    chk("rst_valid", {31'h0, valid_o}, 32'h0);
    chk("rst_swap", {31'h0, swap_o}, 32'h0);
    chk("rst_errcnt", {16'h0, err_cnt_o}, 32'h0);
    @(posedge clk);
    #1;
    rst_n_i = 1'b1;
    model_reset();
  endtask

  task automatic lock_lane0();
    for (int k = 0; k < LOCK; k++) begin
      step(2'b01, 16'h50BC, 2'b00, 2'b00);
      chk("l0_lock_edge", {31'h0, locked_o}, (k == LOCK - 1) ? 32'd1 : 32'd0);
      step(2'b00, 16'h1234, 2'b00, 2'b00);
    end
  endtask

  initial begin
    logic [1:0]  c, de, nt;
    logic [15:0] d;
    int          r, lane;
    rst_n_i = 1'b0; ctrl_i = 2'b00; data_i = 16'h0000;
    disperr_i = 2'b00; notintable_i = 2'b00;
    model_reset();
    #3;
    do_reset();

    // Lane-0 lock, output is the input delayed one cycle
    lock_lane0();
    chk("l0_swap", {31'h0, swap_o}, 32'd0);
    chk("l0_data", {16'h0, data_o}, 32'h1234);

    // Lane-1 lock with byte swap
    do_reset();
    for (int k = 0; k < LOCK; k++) begin
      step(2'b10, 16'hBC50, 2'b00, 2'b00);
      step(2'b00, 16'h3412, 2'b00, 2'b00);
    end
    chk("l1_locked", {31'h0, locked_o}, 32'd1);
    chk("l1_swap", {31'h0, swap_o}, 32'd1);
    chk("l1_data", {16'h0, data_o}, 32'h12BC);
    chk("l1_ctrl", {30'h0, ctrl_o}, 32'h1);

    // Lane conflict while verifying
    do_reset();
    step(2'b01, 16'h50BC, 2'b00, 2'b00);
    step(2'b00, 16'h1234, 2'b00, 2'b00);
    step(2'b01, 16'h50BC, 2'b00, 2'b00);
    step(2'b00, 16'h1234, 2'b00, 2'b00);
    step(2'b10, 16'hBC50, 2'b00, 2'b00);
    for (int k = 0; k < LOCK; k++) begin
      step(2'b00, 16'h3412, 2'b00, 2'b00);
      step(2'b10, 16'hBC50, 2'b00, 2'b00);
      chk("conf_swap", {31'h0, swap_o}, 32'd1);
      chk("conf_lock", {31'h0, locked_o}, (k == LOCK - 1) ? 32'd1 : 32'd0);
    end

    // Loss of lock after LOSS errored words
    do_reset();
    lock_lane0();
    for (int k = 0; k < LOSS; k++) begin
      step(2'b00, 16'h1234, 2'b00, 2'b01);
      chk("loss", {31'h0, locked_o}, (k == LOSS - 1) ? 32'd0 : 32'd1);
    end

    // A good comma in the middle of an error run restarts the miss count
    do_reset();
    lock_lane0();
    for (int k = 0; k < 4; k++) step(2'b00, 16'h1234, 2'b00, 2'b01);
    step(2'b01, 16'h50BC, 2'b00, 2'b00);
    for (int k = 0; k < LOSS - 1; k++) step(2'b00, 16'h1234, 2'b00, 2'b01);
    chk("loss_held", {31'h0, locked_o}, 32'd1);
    step(2'b00, 16'h1234, 2'b00, 2'b01);
    chk("loss_after", {31'h0, locked_o}, 32'd0);

    // Error counter over three errored words while locked
    do_reset();
    lock_lane0();
    for (int k = 0; k < 3; k++) step(2'b00, 16'h1234, 2'b10, 2'b00);
`ifdef GTX_RX_ALIGN_ERR_CNT_EN
    chk("errcnt3", {16'h0, err_cnt_o}, 32'd3);
`else
    chk("errcnt0", {16'h0, err_cnt_o}, 32'd0);
`endif

    // Reset in the middle of lock
    do_reset();
    lock_lane0();
    do_reset();
    step(2'b00, 16'h1234, 2'b00, 2'b00);
    chk("post_rst_lock", {31'h0, locked_o}, 32'd0);

    // Randomized traffic with a preferred comma lane per block
    for (int blk = 0; blk < 20; blk++) begin
      lane = $urandom_range(0, 1);
      for (int i = 0; i < 120; i++) begin
        r = $urandom_range(0, 99);
        d = 16'($urandom);
        c = 2'b00; de = 2'b00; nt = 2'b00;
        if (i % 2 == 0) begin
          if (r < 85) begin
            if (lane == 0) begin d[7:0] = 8'hBC; c = 2'b01; end
            else begin d[15:8] = 8'hBC; c = 2'b10; end
          end else if (r < 90) begin
            if (lane == 0) begin d[15:8] = 8'hBC; c = 2'b10; end
            else begin d[7:0] = 8'hBC; c = 2'b01; end
          end else if (r < 94) begin
            d = 16'hBCBC; c = 2'b11;
          end
        end else begin
          c = 2'($urandom_range(0, 3));
        end
        if ($urandom_range(0, 24) == 0) de = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 29) == 0) nt = 2'($urandom_range(1, 3));
        if ((blk % 5 == 4) && (i >= 60) && (i < 70)) nt = 2'b01;
        step(c, d, de, nt);
        if ((blk == 10) && (i == 50)) do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gtx_rx_align.md
# gtx_rx_align

Receive-side word aligner between the GTX transceiver's 16-bit 8b/10b decoded output and the `gtx_rx` payload decoder. It finds the K28.5 comma and decides whether it arrives in the low or high byte lane. When needed it swaps bytes across adjacent words so the comma always lands in the low lane. A hunt/verify/locked state machine provides link-lock status, and the aligned word is presented with a valid flag.

## Interface
Parameters:
- `COMMA`, default 8'hBC: K-character byte used for alignment (K28.5).
- `LOCK_CNT`, default 4: consecutive same-lane commas required to lock (range 2..15).
- `LOSS_CNT`, default 8: bad events without a good comma before lock is dropped (range 2..15).

Ports:
- `clk_i` in 1: receive user clock (`gt0_rxusrclk2` domain).
- `rst_n_i` in 1: reset; one clock; reset is asynchronous and active-low.
- `ctrl_i` in 2: raw rxcharisk; bit n flags byte lane n.
- `data_i` in 16: raw rxdata; lane0 = [7:0], lane1 = [15:8].
- `disperr_i` in 2: per-lane disparity error.
- `notintable_i` in 2: per-lane not-in-table error.
- `ctrl_o` out 2: aligned charisk.
- `data_o` out 16: aligned data.
- `valid_o` out 1: aligned word is valid (state LOCKED).
- `locked_o` out 1: link locked.
- `swap_o` out 1: byte-swap currently applied.
- `err_cnt_o` out 16: saturating code-error count (see Configuration).

## Operation
- Comma in lane n: `ctrl_i[n]` && byte n == `COMMA`.
- Single-lane comma means exactly one lane holds a comma. Error means any bit of `disperr_i | notintable_i` is set.
- The `prev` register captures `data_i[15:8]` and `ctrl_i[1]` every cycle.
- Output mux:
  - swap=0: data = `data_i`, ctrl = `ctrl_i`.
  - swap=1: data = {`data_i[7:0]`, prev[15:8]}, ctrl = {`ctrl_i[0]`, prev_k}.
- States:
  - **HUNT** (reset state): on a single-lane comma with no error, swap ← (lane==1), cnt ← 1, go to VERIFY. Both-lane commas and errored words are ignored.
  - **VERIFY**:
    - Comma in the swap-selected lane with no error: cnt+1; when cnt+1 == `LOCK_CNT`, go to LOCKED with bad ← 0.
    - Comma in the opposite lane only, or any error: go to HUNT, cnt ← 0.
    - Non-comma clean words: hold.
  - **LOCKED**:
    - Comma in the selected lane with no error: bad ← 0. This includes both-lane commas.
    - Error, or comma only in the opposite lane: bad+1; when bad+1 == `LOSS_CNT`, go to HUNT, cnt ← 0.
    - Good and bad in the same cycle cannot occur, because an errored word is never counted as good.
- swap changes only on the HUNT→VERIFY transition and is held in VERIFY and LOCKED.
- Counters are 4-bit and never wrap, because their exit comparisons bound them.

## Timing
- Reset values:
  - `data_o` = 0, `ctrl_o` = 0, `valid_o` = 0, `locked_o` = 0, `swap_o` = 0, `err_cnt_o` = 0.
  - state HUNT; cnt, bad and `prev` = 0.
- Latency is one cycle: registered outputs in cycle t+1 reflect the inputs and `prev` sampled at t.
- `locked_o`, `valid_o` and `swap_o` are registered copies of the state, updated in the same cycle as the state transition. In the cycle where LOCKED is entered, `data_o` already uses the final swap.
- Lock time from the first comma is `LOCK_CNT` commas. With one comma per 2 words, lock occurs 2·`LOCK_CNT`−1 cycles after the first comma.
- Asserting `rst_n_i` mid-operation clears everything immediately and the block restarts in HUNT. Release of reset is synchronised externally.

## Configuration
- `GTX_RX_ALIGN_ERR_CNT_EN` defined:
  - `err_cnt_o` increments by 1 on each cycle with an error while in LOCKED and saturates at 16'hFFFF.
  - It clears only on reset.
- Undefined: no counter logic is built and `err_cnt_o` is tied to 16'h0000.

## Structure
- Shared package `gtx_pkg` holds:
  - `K28_5` = 8'hBC.
  - The enum `align_state_t` {HUNT, VERIFY, LOCKED}.
  - Lane index constants.
- Single module with no sub-module. The comma detect is two comparators inlined.

## Test plan
- **Lane-0 lock:** words 16'h50BC with ctrl 2'b01 alternating with 16'h1234 with ctrl 2'b00 -> `locked_o` after the 4th comma, `swap_o` = 0, `data_o` = input delayed 1 cycle.
- **Lane-1 lock:** words 16'hBC50 with ctrl 2'b10 alternating with 16'h3412 -> `swap_o` = 1, then `data_o` = 16'h12BC with ctrl 2'b01.
- **Lane conflict in VERIFY:** after 2 lane-0 commas, inject one lane-1 comma -> HUNT, then re-verify with swap = 1; no lock before 4 lane-1 commas.
- **Loss of lock:** once locked, assert `notintable_i` = 2'b01 for 8 cycles with no commas -> `locked_o` falls on cycle 8. With a good comma at cycle 5, lock is held and bad resets.
- **Error counter:** with `GTX_RX_ALIGN_ERR_CNT_EN`, 3 errored words while locked -> `err_cnt_o` = 3. Without the macro, `err_cnt_o` stays 0.
- **Reset mid-lock:** pulse `rst_n_i` low -> all outputs 0 asynchronously, and HUNT on release.
